// File: rtl/bus_slave_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX FSM state type
// for the bus-attached FIFO slave.
package bus_slave_pkg;

  // Word offsets from BASE_ADDR
  localparam int unsigned RegStatus = 0;
  localparam int unsigned RegDataTx = 1;
  localparam int unsigned RegDataRx = 2;
  localparam int unsigned RegCtrl   = 3;

  // STATUS bit positions
  localparam int unsigned StatBusy     = 0;
  localparam int unsigned StatTxFull   = 1;
  localparam int unsigned StatTxEmpty  = 2;
  localparam int unsigned StatRxFull   = 3;
  localparam int unsigned StatRxEmpty  = 4;
  localparam int unsigned StatTxOvf    = 5;
  localparam int unsigned StatRxOvf    = 6;
  localparam int unsigned StatLevelLsb = 8;

  // CTRL bit positions; bits 2..4 are one-shot commands
  localparam int unsigned CtrlIenRx   = 0;
  localparam int unsigned CtrlIenOvf  = 1;
  localparam int unsigned CtrlFlushTx = 2;
  localparam int unsigned CtrlFlushRx = 3;
  localparam int unsigned CtrlClrOvf  = 4;

  typedef enum logic [0:0] {
    TxIdle,
    TxGap
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush. The caller is expected to push only when
// there is room (or a pop happens in the same cycle); flush beats push/pop.
module sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q;
  logic              push_ok, pop_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem[rptr_q];

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr_q] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/bus_slave_fifo.sv
// Bus slave exposing a TX FIFO drained to a channel by a small FSM and an
// RX FIFO filled from the channel, with status, control and interrupt.
module bus_slave_fifo
  import bus_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              HCLK_i,
  input  logic              HRESETn_i,
  input  logic              HSEL_i,
  input  logic [31:0]       HADDR_bi,
  input  logic              HWRITE_i,
  input  logic [DATA_W-1:0] HWDATA_bi,
  output logic [DATA_W-1:0] HRDATA_bo,
  input  logic [DATA_W-1:0] data_rx_bi,
  input  logic              data_rx_wr_i,
  input  logic              busy_i,
  output logic [DATA_W-1:0] data_tx_bo,
  output logic              data_tx_wr_o,
  output logic              irq_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       off;
  logic              sel_status, sel_tx, sel_rx, sel_ctrl;
  logic              wr_tx, rd_rx, wr_ctrl;
  logic              tx_flush, rx_flush, ovf_clr;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0]     tx_level, rx_level;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic              tx_ovf_q, rx_ovf_q;
  logic              ien_rx_q, ien_ovf_q;
  tx_state_e         tx_state_q;
  logic [31:0]       status_word, rd_word;

  // Offset arithmetic wraps below BASE_ADDR, so those addresses never decode
  assign off        = HADDR_bi - BASE_ADDR;
  assign sel_status = HSEL_i && (off == 32'(RegStatus));
  assign sel_tx     = HSEL_i && (off == 32'(RegDataTx));
  assign sel_rx     = HSEL_i && (off == 32'(RegDataRx));
  assign sel_ctrl   = HSEL_i && (off == 32'(RegCtrl));

  assign wr_tx   = sel_tx && HWRITE_i;
  assign rd_rx   = sel_rx && !HWRITE_i;
  assign wr_ctrl = sel_ctrl && HWRITE_i;

  assign tx_flush = wr_ctrl && HWDATA_bi[CtrlFlushTx];
  assign rx_flush = wr_ctrl && HWDATA_bi[CtrlFlushRx];
  assign ovf_clr  = wr_ctrl && HWDATA_bi[CtrlClrOvf];

  assign tx_push = wr_tx && !tx_full;
  assign tx_pop  = (tx_state_q == TxIdle) && (tx_level != '0) && !busy_i && !tx_flush;
  assign rx_pop  = rd_rx && !rx_empty;
  // A pop in the same cycle frees the slot for an incoming word
  assign rx_push = data_rx_wr_i && (!rx_full || rx_pop);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (HCLK_i),
    .rst_n (HRESETn_i),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .wdata (HWDATA_bi),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (HCLK_i),
    .rst_n (HRESETn_i),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .wdata (data_rx_bi),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // Assemble STATUS and select the read data for the addressed register
  always_comb begin
    status_word                         = '0;
    status_word[StatBusy]               = busy_i;
    status_word[StatTxFull]             = tx_full;
    status_word[StatTxEmpty]            = tx_empty;
    status_word[StatRxFull]             = rx_full;
    status_word[StatRxEmpty]            = rx_empty;
    status_word[StatTxOvf]              = tx_ovf_q;
    status_word[StatRxOvf]              = rx_ovf_q;
    status_word[StatLevelLsb +: 8]      = 8'(rx_level);

    rd_word = '0;
    if (sel_status) rd_word = status_word;
    if (sel_rx && !rx_empty) rd_word = 32'(rx_head);
    if (sel_ctrl) rd_word = {30'b0, ien_ovf_q, ien_rx_q};
  end

  // Read data register; only updates on a read access
  always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
    if (!HRESETn_i) begin
      HRDATA_bo <= '0;
    end else if (HSEL_i && !HWRITE_i) begin
      HRDATA_bo <= rd_word[DATA_W-1:0];
    end
  end

  // Stored CTRL enables; command bits are never stored
  always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
    if (!HRESETn_i) begin
      ien_rx_q  <= 1'b0;
      ien_ovf_q <= 1'b0;
    end else if (wr_ctrl) begin
      ien_rx_q  <= HWDATA_bi[CtrlIenRx];
      ien_ovf_q <= HWDATA_bi[CtrlIenOvf];
    end
  end

  // Sticky overflow flags; a new overflow beats a simultaneous clear
  always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
    if (!HRESETn_i) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_ovf_q <= (tx_ovf_q && !ovf_clr) || (wr_tx && tx_full);
      rx_ovf_q <= (rx_ovf_q && !ovf_clr) || (data_rx_wr_i && rx_full && !rx_pop);
    end
  end

  // TX issue FSM: one word, then a mandatory idle cycle for busy_i to rise
  always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
    if (!HRESETn_i) begin
      tx_state_q   <= TxIdle;
      data_tx_bo   <= '0;
      data_tx_wr_o <= 1'b0;
    end else begin
      data_tx_wr_o <= 1'b0;
      case (tx_state_q)
        TxIdle: begin
          if (tx_pop) begin
            data_tx_bo   <= tx_head;
            data_tx_wr_o <= 1'b1;
            tx_state_q   <= TxGap;
          end
        end
        TxGap:   tx_state_q <= TxIdle;
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  // Level interrupt registered from the current flag state
  always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
    if (!HRESETn_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= (ien_rx_q && !rx_empty) || (ien_ovf_q && (tx_ovf_q || rx_ovf_q));
    end
  end

endmodule

// File: tb/tb_bus_slave_fifo.sv
// Directed bench for bus_slave_fifo at default parameters (depth 4, 32-bit).
module tb_bus_slave_fifo;

  localparam int unsigned DW = 32;

  logic          HCLK_i       = 1'b0;
  logic          HRESETn_i    = 1'b0;
  logic          HSEL_i       = 1'b0;
  logic [31:0]   HADDR_bi     = '0;
  logic          HWRITE_i     = 1'b0;
  logic [DW-1:0] HWDATA_bi    = '0;
  logic [DW-1:0] HRDATA_bo;
  logic [DW-1:0] data_rx_bi   = '0;
  logic          data_rx_wr_i = 1'b0;
  logic          busy_i       = 1'b0;
  logic [DW-1:0] data_tx_bo;
  logic          data_tx_wr_o;
  logic          irq_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  logic [31:0] tx_q[$];
  int          tx_cyc[$];

  bus_slave_fifo dut (
    .HCLK_i       (HCLK_i),
    .HRESETn_i    (HRESETn_i),
    .HSEL_i       (HSEL_i),
    .HADDR_bi     (HADDR_bi),
    .HWRITE_i     (HWRITE_i),
    .HWDATA_bi    (HWDATA_bi),
    .HRDATA_bo    (HRDATA_bo),
    .data_rx_bi   (data_rx_bi),
    .data_rx_wr_i (data_rx_wr_i),
    .busy_i       (busy_i),
    .data_tx_bo   (data_tx_bo),
    .data_tx_wr_o (data_tx_wr_o),
    .irq_o        (irq_o)
  );

  always #5 HCLK_i = ~HCLK_i;

  always @(posedge HCLK_i) cyc <= cyc + 1;

  // Record every transmit strobe with its data and cycle number
  always @(negedge HCLK_i) begin
    if (data_tx_wr_o) begin
      tx_q.push_back(data_tx_bo);
      tx_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK_i);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    HSEL_i = 1'b1; HWRITE_i = 1'b1; HADDR_bi = a; HWDATA_bi = d;
    tick(1);
    HSEL_i = 1'b0; HWRITE_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    HSEL_i = 1'b1; HWRITE_i = 1'b0; HADDR_bi = a;
    tick(1);
    HSEL_i = 1'b0;
    d = HRDATA_bo;
  endtask

  task automatic rx_push(input logic [31:0] d);
    data_rx_bi = d; data_rx_wr_i = 1'b1;
    tick(1);
    data_rx_wr_i = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("tx_count", tx_q.size(), n);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          s;
    int          k;

    // Reset state
    #12;
    check("rst_hrdata", HRDATA_bo, 0);
    check("rst_tx_wr", data_tx_wr_o, 0);
    check("rst_tx_data", data_tx_bo, 0);
    check("rst_irq", irq_o, 0);
    @(posedge HCLK_i); #1 HRESETn_i = 1'b1;
    tick(1);
    bus_read(0, rd); check("status_idle", rd, 32'h14);
    bus_read(3, rd); check("ctrl_rst", rd, 0);

    // Two TX words issue two cycles apart
    bus_write(1, 32'hA5);
    bus_write(1, 32'h5A);
    wait_tx(2, 20);
    if (tx_q.size() >= 2) begin
      check("tx0_data", tx_q[0], 32'hA5);
      check("tx1_data", tx_q[1], 32'h5A);
      check("tx_spacing", tx_cyc[1] - tx_cyc[0], 2);
    end
    tick(2);
    check("tx_hold", data_tx_bo, 32'h5A);
    check("tx_wr_low", data_tx_wr_o, 0);

    // Busy channel: fifth write overflows, nothing issues until busy drops
    tx_q.delete(); tx_cyc.delete();
    busy_i = 1'b1;
    for (int i = 1; i <= 5; i++) bus_write(1, i);
    bus_read(0, rd); check("status_tx_ovf", rd, 32'h33);
    tick(3);
    check("tx_none_busy", tx_q.size(), 0);
    busy_i = 1'b0;
    wait_tx(4, 30);
    for (int i = 0; i < 4; i++) if (i < tx_q.size()) check("tx_fifo_order", tx_q[i], i + 1);
    tick(3);
    check("tx_fifth_dropped", tx_q.size(), 4);
    bus_read(0, rd); check("status_ovf_sticky", rd, 32'h34);
    bus_write(3, 32'h10);
    bus_read(0, rd); check("status_ovf_clr", rd, 32'h14);

    // RX pops in order, then empty read returns 0
    rx_push(32'h11);
    rx_push(32'h22);
    bus_read(0, rd); check("status_rx_lvl2", rd, 32'h204);
    bus_read(2, rd); check("rx_pop0", rd, 32'h11);
    bus_read(2, rd); check("rx_pop1", rd, 32'h22);
    HADDR_bi = 0; HSEL_i = 1'b0;
    tick(1);
    check("hsel_low_hold", HRDATA_bo, 32'h22);
    bus_read(2, rd); check("rx_pop_empty", rd, 0);
    bus_read(0, rd); check("status_rx_empty", rd, 32'h14);
    bus_read(4, rd); check("unmapped_read", rd, 0);
    bus_write(5, 32'hFF);
    bus_read(0, rd); check("unmapped_write", rd, 32'h14);

    // RX full with push and pop in the same cycle
    for (int i = 0; i < 4; i++) rx_push(32'hA0 + i);
    bus_read(0, rd); check("status_rx_full", rd, 32'h40C);
    data_rx_bi = 32'hB0; data_rx_wr_i = 1'b1;
    HSEL_i = 1'b1; HWRITE_i = 1'b0; HADDR_bi = 2;
    tick(1);
    HSEL_i = 1'b0; data_rx_wr_i = 1'b0;
    check("rx_simul_head", HRDATA_bo, 32'hA0);
    bus_read(0, rd); check("status_rx_simul", rd, 32'h40C);
    bus_read(2, rd); check("rx_drain_a1", rd, 32'hA1);
    bus_read(2, rd); check("rx_drain_a2", rd, 32'hA2);
    bus_read(2, rd); check("rx_drain_a3", rd, 32'hA3);
    bus_read(2, rd); check("rx_drain_b0", rd, 32'hB0);

    // RX overflow, flush keeps the flag, clear removes it
    for (int i = 0; i < 5; i++) rx_push(32'hC0 + i);
    bus_read(0, rd); check("status_rx_ovf", rd, 32'h44C);
    bus_write(3, 32'h08);
    bus_read(0, rd); check("status_rx_flush", rd, 32'h54);
    bus_write(3, 32'h10);
    bus_read(0, rd); check("status_rx_clr", rd, 32'h14);

    // RX interrupt follows RX occupancy
    bus_write(3, 32'h1);
    bus_read(3, rd); check("ctrl_readback", rd, 32'h1);
    tick(1);
    check("irq_rx_idle", irq_o, 0);
    rx_push(32'h33);
    tick(2);
    check("irq_rx_set", irq_o, 1);
    bus_read(2, rd); check("rx_pop_33", rd, 32'h33);
    tick(2);
    check("irq_rx_clr", irq_o, 0);

    // Overflow interrupt, then TX flush while busy
    bus_write(3, 32'h2);
    busy_i = 1'b1;
    for (int i = 0; i < 5; i++) bus_write(1, 32'hF0 + i);
    tick(2);
    check("irq_ovf_set", irq_o, 1);
    bus_write(3, 32'h12);
    tick(2);
    check("irq_ovf_clr", irq_o, 0);
    bus_read(0, rd); check("status_tx_full", rd, 32'h13);
    bus_read(3, rd); check("ctrl_ien_ovf", rd, 32'h2);
    bus_write(3, 32'h04);
    bus_read(0, rd); check("status_tx_flush", rd, 32'h15);
    s = tx_q.size();
    busy_i = 1'b0;
    tick(4);
    check("tx_flushed_none", tx_q.size(), s);

    // Overflow clear in the same cycle as a new RX overflow keeps the flag
    for (int i = 0; i < 4; i++) rx_push(32'hD0 + i);
    data_rx_bi = 32'hD4; data_rx_wr_i = 1'b1;
    HSEL_i = 1'b1; HWRITE_i = 1'b1; HADDR_bi = 3; HWDATA_bi = 32'h10;
    tick(1);
    HSEL_i = 1'b0; HWRITE_i = 1'b0; data_rx_wr_i = 1'b0;
    bus_read(0, rd); check("ovf_clr_race", rd, 32'h44C);
    bus_write(3, 32'h18);
    bus_read(0, rd); check("status_rx_reset", rd, 32'h14);

    // Reset in the GAP cycle with TX still holding a word
    bus_write(3, 32'h1);
    rx_push(32'h77);
    bus_read(0, rd); check("status_pre_rst", rd, 32'h104);
    bus_write(1, 32'hE1);
    bus_write(1, 32'hE2);
    k = 0;
    while (data_tx_wr_o !== 1'b1 && k < 20) begin
      @(negedge HCLK_i);
      k++;
    end
    check("gap_pulse_seen", data_tx_wr_o, 1);
    check("gap_irq_high", irq_o, 1);
    #1 HRESETn_i = 1'b0;
    #1;
    check("arst_tx_wr", data_tx_wr_o, 0);
    check("arst_tx_data", data_tx_bo, 0);
    check("arst_irq", irq_o, 0);
    check("arst_hrdata", HRDATA_bo, 0);
    @(posedge HCLK_i); #1 HRESETn_i = 1'b1;
    s = tx_q.size();
    tick(3);
    check("post_rst_no_tx", tx_q.size(), s);
    bus_read(0, rd); check("post_rst_status", rd, 32'h14);
    bus_read(3, rd); check("post_rst_ctrl", rd, 0);
    check("post_rst_irq", irq_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
